rf_issue_gate: RTL and testbench

//  Operand-fetch/issue stage directly upstream of regfile. Accepts decoded instrs (valid/ready),

---
 rtl/maverickOne_pkg.sv | 24 ++
 rtl/rf_hazard_chk.sv | 28 ++
 rtl/rf_issue_gate.sv | 121 ++++++++++++
 tb/tb_rf_issue_gate.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// Shared core constants and the issue-stage output bundle.
// Imported by the operand-fetch/issue stage and its hazard checker.
package maverickOne_pkg;

    localparam int NUM_REGS = 32;
    localparam int XLEN     = 64;
    localparam int META_W   = 64;
    localparam int AW       = $clog2(NUM_REGS);

    typedef struct packed {
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   rs3;
        logic              rd_used;
        logic [AW-1:0]     rd;
        logic [META_W-1:0] meta;
    } issue_pkt_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

endpackage

// File: rtl/rf_hazard_chk.sv
// RAW/WAW check against the regfile scoreboard locks.
// x0 is never a hazard, whatever its lock bit says.
module rf_hazard_chk
    import maverickOne_pkg::*;
(
    input  logic [2:0]          rs_used,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    input  logic [AW-1:0]       rs3_addr,
    input  logic                rd_used,
    input  logic [AW-1:0]       rd_addr,
    input  logic [NUM_REGS-1:0] locks,
    output logic                hazard
);

    logic [2:0] src_hit;
    logic       dst_hit;

    always_comb begin
        src_hit    = '0;
        src_hit[0] = rs_used[0] & (rs1_addr != '0) & locks[rs1_addr];
        src_hit[1] = rs_used[1] & (rs2_addr != '0) & locks[rs2_addr];
        src_hit[2] = rs_used[2] & (rs3_addr != '0) & locks[rs3_addr];
        dst_hit    = rd_used & (rd_addr != '0) & locks[rd_addr];
        hazard     = (|src_hit) | dst_hit;
    end

endmodule

// File: rtl/rf_issue_gate.sv
// Operand-fetch/issue stage: holds an instr on locked regs, locks rd
// on issue and registers operands into a one-entry slot for execute.
module rf_issue_gate
    import maverickOne_pkg::*;
(
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [2:0]          rs_used_i,
    input  logic [AW-1:0]       rs1_addr_i,
    input  logic [AW-1:0]       rs2_addr_i,
    input  logic [AW-1:0]       rs3_addr_i,
    input  logic                rd_used_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [META_W-1:0]   meta_i,
    output logic [AW-1:0]       rs1_addr_o,
    output logic [AW-1:0]       rs2_addr_o,
    output logic [AW-1:0]       rs3_addr_o,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic [XLEN-1:0]     rs3_data_i,
    input  logic [NUM_REGS-1:0] locks_i,
    output logic                wr_lock_en_o,
    output logic [AW-1:0]       wr_lock_addr_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_rs1_o,
    output logic [XLEN-1:0]     out_rs2_o,
    output logic [XLEN-1:0]     out_rs3_o,
    output logic                out_rd_used_o,
    output logic [AW-1:0]       out_rd_addr_o,
    output logic [META_W-1:0]   out_meta_o,
    output logic [31:0]         stall_cnt_o
);

    slot_state_e state_q;
    slot_state_e state_d;
    issue_pkt_t  pkt_q;
    issue_pkt_t  pkt_d;
    logic        hazard;
    logic        slot_free;
    logic        fire;
    logic [31:0] stall_cnt_q;

    assign rs1_addr_o = rs1_addr_i;
    assign rs2_addr_o = rs2_addr_i;
    assign rs3_addr_o = rs3_addr_i;

    rf_hazard_chk u_hazard_chk (
        .rs_used  (rs_used_i),
        .rs1_addr (rs1_addr_i),
        .rs2_addr (rs2_addr_i),
        .rs3_addr (rs3_addr_i),
        .rd_used  (rd_used_i),
        .rd_addr  (rd_addr_i),
        .locks    (locks_i),
        .hazard   (hazard)
    );

    // Gating on arst_ni keeps the stage silent while the regfile is in reset.
    assign out_valid_o   = (state_q == SLOT_FULL);
    assign slot_free     = ~out_valid_o | out_ready_i;
    assign instr_ready_o = arst_ni & ~hazard & slot_free;
    assign fire          = instr_valid_i & instr_ready_o;

    always_comb begin
        wr_lock_en_o   = 1'b0;
        wr_lock_addr_o = '0;
        if (fire && rd_used_i && (rd_addr_i != '0)) begin
            wr_lock_en_o   = 1'b1;
            wr_lock_addr_o = rd_addr_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SLOT_EMPTY: if (fire) state_d = SLOT_FULL;
            SLOT_FULL:  if (out_ready_i && !fire) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        pkt_d         = '0;
        pkt_d.rs1     = rs1_data_i;
        pkt_d.rs2     = rs2_data_i;
        pkt_d.rs3     = rs3_data_i;
        pkt_d.rd_used = rd_used_i;
        pkt_d.rd      = rd_addr_i;
        pkt_d.meta    = meta_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= SLOT_EMPTY;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (fire) pkt_q <= pkt_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_q <= '0;
        end else if (instr_valid_i && hazard && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign out_rs1_o     = pkt_q.rs1;
    assign out_rs2_o     = pkt_q.rs2;
    assign out_rs3_o     = pkt_q.rs3;
    assign out_rd_used_o = pkt_q.rd_used;
    assign out_rd_addr_o = pkt_q.rd;
    assign out_meta_o    = pkt_q.meta;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_rf_issue_gate.sv
// Directed and constrained-random checks of rf_issue_gate against a
// small regfile model with lock-wins scoreboard.
module tb_rf_issue_gate;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [2:0]  rs_used_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rs3_addr_i;
    logic        rd_used_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] meta_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rs3_addr_o;
    logic [63:0] rs1_data_i, rs2_data_i, rs3_data_i;
    logic [31:0] locks_i;
    logic        wr_lock_en_o;
    logic [4:0]  wr_lock_addr_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_rs1_o, out_rs2_o, out_rs3_o;
    logic        out_rd_used_o;
    logic [4:0]  out_rd_addr_o;
    logic [63:0] out_meta_o;
    logic [31:0] stall_cnt_o;

    logic [63:0] regs [32];
    logic [31:0] locks_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_issue_gate dut (
        .clk_i          (clk),
        .arst_ni        (arst_ni),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .rs_used_i      (rs_used_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs3_addr_i     (rs3_addr_i),
        .rd_used_i      (rd_used_i),
        .rd_addr_i      (rd_addr_i),
        .meta_i         (meta_i),
        .rs1_addr_o     (rs1_addr_o),
        .rs2_addr_o     (rs2_addr_o),
        .rs3_addr_o     (rs3_addr_o),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .rs3_data_i     (rs3_data_i),
        .locks_i        (locks_i),
        .wr_lock_en_o   (wr_lock_en_o),
        .wr_lock_addr_o (wr_lock_addr_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_rs1_o      (out_rs1_o),
        .out_rs2_o      (out_rs2_o),
        .out_rs3_o      (out_rs3_o),
        .out_rd_used_o  (out_rd_used_o),
        .out_rd_addr_o  (out_rd_addr_o),
        .out_meta_o     (out_meta_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Regfile model: combinational reads, lock-wins scoreboard, all locked in reset.
    assign rs1_data_i = regs[rs1_addr_o];
    assign rs2_data_i = regs[rs2_addr_o];
    assign rs3_data_i = regs[rs3_addr_o];
    assign locks_i    = arst_ni ? locks_q : '1;

    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) locks_q <= '0;
        else locks_q <= (locks_q & ~clr_mask) | set_mask |
                        (wr_lock_en_o ? (32'd1 << wr_lock_addr_o) : 32'd0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic haz_f(input logic [2:0] u, input logic [4:0] a1,
                                   input logic [4:0] a2, input logic [4:0] a3,
                                   input logic du, input logic [4:0] d,
                                   input logic [31:0] lk);
        logic h;
        h = 1'b0;
        if (u[0] && a1 != 0 && lk[a1]) h = 1'b1;
        if (u[1] && a2 != 0 && lk[a2]) h = 1'b1;
        if (u[2] && a3 != 0 && lk[a3]) h = 1'b1;
        if (du && d != 0 && lk[d]) h = 1'b1;
        return h;
    endfunction

    task automatic drive(input logic v, input logic [2:0] u, input logic [4:0] a1,
                         input logic du, input logic [4:0] d, input logic [63:0] m);
        instr_valid_i = v;
        rs_used_i     = u;
        rs1_addr_i    = a1;
        rs2_addr_i    = 5'd0;
        rs3_addr_i    = 5'd0;
        rd_used_i     = du;
        rd_addr_i     = d;
        meta_i        = m;
    endtask

    logic        m_valid;
    logic [63:0] m_rs1, m_rs2, m_rs3, m_meta;
    logic        m_rdu;
    logic [4:0]  m_rd;
    logic [31:0] m_stall;
    logic        e_haz, e_rdy, e_fire, e_len;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {32'hCAFE_0000, 32'(i)};
        set_mask    = '0;
        clr_mask    = '0;
        out_ready_i = 1'b1;
        arst_ni     = 1'b0;
        drive(1'b1, 3'b001, 5'd1, 1'b1, 5'd5, 64'hA);

        // reset: all locks reported, nothing may fire
        #2;
        chk("rst_ready", instr_ready_o, 0);
        chk("rst_lock_en", wr_lock_en_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_meta", out_meta_o, 0);
        @(posedge clk); #1;
        chk("rst_out_valid2", out_valid_o, 0);

        // A: rd=5 from rs1=1 fires immediately
        @(negedge clk);
        arst_ni = 1'b1;
        #1;
        chk("A_ready", instr_ready_o, 1);
        chk("A_lock_en", wr_lock_en_o, 1);
        chk("A_lock_addr", wr_lock_addr_o, 5);
        chk("A_rs1_addr_o", rs1_addr_o, 1);
        @(posedge clk); #1;
        chk("A_out_valid", out_valid_o, 1);
        chk("A_out_rs1", out_rs1_o, 64'hCAFE_0000_0000_0001);
        chk("A_out_rd", out_rd_addr_o, 5);
        chk("A_out_meta", out_meta_o, 64'hA);

        // B: rs1=5 stalls on the fresh lock until x5 is released
        @(negedge clk);
        drive(1'b1, 3'b001, 5'd5, 1'b1, 5'd6, 64'hB);
        #1;
        chk("B_ready_stall", instr_ready_o, 0);
        chk("B_lock_en_stall", wr_lock_en_o, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            chk("B_stall_cnt", stall_cnt_o, 64'(k));
            @(negedge clk); #1;
            chk("B_ready_hold", instr_ready_o, 0);
        end
        chk("B_drained", out_valid_o, 0);
        regs[5]  = 64'h5555_AAAA_0000_0005;
        clr_mask = 32'd1 << 5;
        @(posedge clk); #1;
        clr_mask = '0;
        chk("B_stall_cnt_unlock", stall_cnt_o, 4);
        @(negedge clk); #1;
        chk("B_ready_fire", instr_ready_o, 1);
        chk("B_lock_en", wr_lock_en_o, 1);
        chk("B_lock_addr", wr_lock_addr_o, 6);
        @(posedge clk); #1;
        chk("B_out_rs1", out_rs1_o, 64'h5555_AAAA_0000_0005);
        chk("B_out_meta", out_meta_o, 64'hB);
        chk("B_stall_final", stall_cnt_o, 4);

        // C: rd=x0 with x0 lock forced never hazards and never locks
        @(negedge clk);
        drive(1'b0, 3'b000, 5'd0, 1'b1, 5'd0, 64'hC);
        set_mask = 32'd1;
        @(posedge clk); #1;
        set_mask = '0;
        @(negedge clk);
        instr_valid_i = 1'b1;
        #1;
        chk("C_x0_locked", locks_i[0], 1);
        chk("C_ready", instr_ready_o, 1);
        chk("C_lock_en", wr_lock_en_o, 0);
        chk("C_lock_addr", wr_lock_addr_o, 0);
        @(posedge clk); #1;
        chk("C_out_rd", out_rd_addr_o, 0);
        chk("C_out_rd_used", out_rd_used_o, 1);
        chk("C_out_meta", out_meta_o, 64'hC);

        // D: back-pressure holds slot stable, then replace in same cycle
        @(negedge clk);
        out_ready_i = 1'b0;
        drive(1'b1, 3'b001, 5'd2, 1'b1, 5'd7, 64'hD);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("D_ready_bp", instr_ready_o, 0);
            @(posedge clk); #1;
            chk("D_valid_bp", out_valid_o, 1);
            chk("D_meta_bp", out_meta_o, 64'hC);
            @(negedge clk);
        end
        chk("D_stall_bp", stall_cnt_o, 4);
        out_ready_i = 1'b1;
        #1;
        chk("D_ready_replace", instr_ready_o, 1);
        chk("D_lock_addr", wr_lock_addr_o, 7);
        @(posedge clk); #1;
        chk("D_valid", out_valid_o, 1);
        chk("D_meta", out_meta_o, 64'hD);
        chk("D_out_rs1", out_rs1_o, 64'hCAFE_0000_0000_0002);

        // E: reset mid-stall with slot full
        @(negedge clk);
        out_ready_i = 1'b0;
        drive(1'b1, 3'b001, 5'd7, 1'b0, 5'd0, 64'hE);
        @(posedge clk); #1;
        chk("E_stall", stall_cnt_o, 5);
        chk("E_valid", out_valid_o, 1);
        #2;
        arst_ni = 1'b0;
        #1;
        chk("E_rst_valid", out_valid_o, 0);
        chk("E_rst_stall", stall_cnt_o, 0);
        chk("E_rst_ready", instr_ready_o, 0);
        chk("E_rst_lock_en", wr_lock_en_o, 0);
        chk("E_rst_meta", out_meta_o, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("E_rst_no_lock", wr_lock_en_o, 0);
        end
        @(negedge clk);
        instr_valid_i = 1'b0;
        out_ready_i   = 1'b1;
        arst_ni       = 1'b1;

        // random traffic against the scoreboard
        m_valid = 1'b0;
        m_stall = '0;
        m_rs1 = '0; m_rs2 = '0; m_rs3 = '0; m_meta = '0; m_rdu = 1'b0; m_rd = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            instr_valid_i = 1'($urandom_range(0, 1));
            rs_used_i     = 3'($urandom_range(0, 7));
            rs1_addr_i    = 5'($urandom_range(0, 7));
            rs2_addr_i    = 5'($urandom_range(0, 7));
            rs3_addr_i    = 5'($urandom_range(0, 7));
            rd_used_i     = 1'($urandom_range(0, 1));
            rd_addr_i     = 5'($urandom_range(0, 7));
            meta_i        = {$urandom, $urandom};
            out_ready_i   = ($urandom_range(0, 3) != 0);
            clr_mask      = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'd0;
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(1, 7)] = {$urandom, $urandom};
            #1;
            e_haz  = haz_f(rs_used_i, rs1_addr_i, rs2_addr_i, rs3_addr_i,
                           rd_used_i, rd_addr_i, locks_q);
            e_rdy  = ~e_haz & (~m_valid | out_ready_i);
            e_fire = instr_valid_i & e_rdy;
            e_len  = e_fire & rd_used_i & (rd_addr_i != 0);
            chk("R_ready", instr_ready_o, e_rdy);
            chk("R_lock_en", wr_lock_en_o, e_len);
            if (e_len) chk("R_lock_addr", wr_lock_addr_o, rd_addr_i);
            if (e_fire) begin
                m_rs1  = regs[rs1_addr_i];
                m_rs2  = regs[rs2_addr_i];
                m_rs3  = regs[rs3_addr_i];
                m_rdu  = rd_used_i;
                m_rd   = rd_addr_i;
                m_meta = meta_i;
            end
            if (instr_valid_i && e_haz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            @(posedge clk); #1;
            if (e_fire) m_valid = 1'b1;
            else if (out_ready_i) m_valid = 1'b0;
            chk("R_out_valid", out_valid_o, m_valid);
            chk("R_stall", stall_cnt_o, m_stall);
            if (m_valid) begin
                chk("R_out_rs1", out_rs1_o, m_rs1);
                chk("R_out_rs2", out_rs2_o, m_rs2);
                chk("R_out_rs3", out_rs3_o, m_rs3);
                chk("R_out_rd", {m_rdu, out_rd_addr_o}, {m_rdu, m_rd});
                chk("R_out_rd_used", out_rd_used_o, m_rdu);
                chk("R_out_meta", out_meta_o, m_meta);
            end
        end
        clr_mask = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
